// File: rtl/pop_rr_arbiter_if.sv
// Bus between the five FWFT source FIFOs, the pop arbiter and the downstream consumer.
// The arbiter takes the slave modport and the environment takes the master modport.
interface pop_rr_arbiter_if #(
  parameter int unsigned DATA_W = 6
);
  logic              fifo0_empty;
  logic              fifo1_empty;
  logic              fifo2_empty;
  logic              fifo3_empty;
  logic              fifo4_empty;
  logic [DATA_W-1:0] fifo0_data;
  logic [DATA_W-1:0] fifo1_data;
  logic [DATA_W-1:0] fifo2_data;
  logic [DATA_W-1:0] fifo3_data;
  logic [DATA_W-1:0] fifo4_data;
  logic              pause;
  logic              fifo0_pop;
  logic              fifo1_pop;
  logic              fifo2_pop;
  logic              fifo3_pop;
  logic              fifo4_pop;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic [2:0]        idx;
  logic              IDLE;

  modport master (
    output fifo0_empty, fifo1_empty, fifo2_empty, fifo3_empty, fifo4_empty,
    output fifo0_data, fifo1_data, fifo2_data, fifo3_data, fifo4_data,
    output pause,
    input  fifo0_pop, fifo1_pop, fifo2_pop, fifo3_pop, fifo4_pop,
    input  data_out, valid, idx, IDLE
  );

  modport slave (
    input  fifo0_empty, fifo1_empty, fifo2_empty, fifo3_empty, fifo4_empty,
    input  fifo0_data, fifo1_data, fifo2_data, fifo3_data, fifo4_data,
    input  pause,
    output fifo0_pop, fifo1_pop, fifo2_pop, fifo3_pop, fifo4_pop,
    output data_out, valid, idx, IDLE
  );
endinterface

// File: rtl/pop_rr_arbiter.sv
// Round-robin pop arbiter over five FWFT FIFOs feeding the pop counter bank.
// Pop strobes are combinational and state-gated; the popped word is registered one cycle later.
module pop_rr_arbiter #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned NUM_Q  = 5
) (
  input  logic                 clk,
  input  logic                 reset_L,
  pop_rr_arbiter_if.slave      bus
);
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_INIT   = 2'd1,
    S_IDLE   = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_found;
  logic              pop_en;
  logic              do_pop;
  logic [NUM_Q-1:0]  empty_vec;
  logic [NUM_Q-1:0]  pop_vec;
  logic [DATA_W-1:0] grant_data;

  assign empty_vec = {bus.fifo4_empty, bus.fifo3_empty, bus.fifo2_empty,
                      bus.fifo1_empty, bus.fifo0_empty};

  // Pops only from IDLE/ACTIVE; RESET is entered asynchronously so pops drop with reset_L.
  assign pop_en = ((state == S_IDLE) || (state == S_ACTIVE)) && !bus.pause;
  assign do_pop = pop_en && grant_found;

  // First non-empty FIFO scanning upward from rr_ptr, wrapping modulo NUM_Q.
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_Q; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_Q;
      if (!grant_found && !empty_vec[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    case (grant_idx)
      3'd0:    grant_data = bus.fifo0_data;
      3'd1:    grant_data = bus.fifo1_data;
      3'd2:    grant_data = bus.fifo2_data;
      3'd3:    grant_data = bus.fifo3_data;
      3'd4:    grant_data = bus.fifo4_data;
      default: grant_data = '0;
    endcase
  end

  always_comb begin
    pop_vec = '0;
    if (do_pop) pop_vec[grant_idx] = 1'b1;
  end

  assign bus.fifo0_pop = pop_vec[0];
  assign bus.fifo1_pop = pop_vec[1];
  assign bus.fifo2_pop = pop_vec[2];
  assign bus.fifo3_pop = pop_vec[3];
  assign bus.fifo4_pop = pop_vec[4];

  // State, pointer and registered output word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state        <= S_RESET;
      rr_ptr       <= '0;
      bus.data_out <= '0;
      bus.valid    <= 1'b0;
      bus.idx      <= '0;
      bus.IDLE     <= 1'b0;
    end else begin
      bus.valid <= do_pop;
      if (do_pop) begin
        bus.data_out <= grant_data;
        bus.idx      <= grant_idx;
        rr_ptr       <= (grant_idx == IDX_W'(NUM_Q - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
      case (state)
        S_RESET: begin
          state    <= S_INIT;
          bus.IDLE <= 1'b0;
        end
        S_INIT: begin
          state    <= S_IDLE;
          bus.IDLE <= 1'b1;
        end
        S_IDLE: begin
          if (do_pop) begin
            state    <= S_ACTIVE;
            bus.IDLE <= 1'b0;
          end else begin
            bus.IDLE <= 1'b1;
          end
        end
        S_ACTIVE: begin
          // Pause always means no pop, so either condition returns to IDLE.
          if (!grant_found || bus.pause) begin
            state    <= S_IDLE;
            bus.IDLE <= 1'b1;
          end else begin
            bus.IDLE <= 1'b0;
          end
        end
        default: begin
          state    <= S_RESET;
          bus.IDLE <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pop_rr_arbiter.sv
// Directed bench for pop_rr_arbiter: hand-computed grant order, latency, pause and reset cases.
module tb_pop_rr_arbiter;
  localparam int unsigned DATA_W = 6;

  logic clk;
  logic reset_L;
  int   errors;
  int   checks;

  pop_rr_arbiter_if #(.DATA_W(DATA_W)) bus ();

  pop_rr_arbiter #(.DATA_W(DATA_W), .NUM_Q(5)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned pops();
    return 32'({bus.fifo4_pop, bus.fifo3_pop, bus.fifo2_pop, bus.fifo1_pop, bus.fifo0_pop});
  endfunction

  task automatic set_empty(input logic [4:0] e);
    bus.fifo0_empty = e[0];
    bus.fifo1_empty = e[1];
    bus.fifo2_empty = e[2];
    bus.fifo3_empty = e[3];
    bus.fifo4_empty = e[4];
  endtask

  // Advance past the next rising edge so registered outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input int unsigned q);
    check_eq({tag, "_valid"}, 32'(bus.valid), 1);
    check_eq({tag, "_idx"}, 32'(bus.idx), q);
    check_eq({tag, "_data"}, 32'(bus.data_out), 32'h10 + q);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_L = 1'b0;
    bus.pause = 1'b0;
    bus.fifo0_data = 6'h10;
    bus.fifo1_data = 6'h11;
    bus.fifo2_data = 6'h12;
    bus.fifo3_data = 6'h13;
    bus.fifo4_data = 6'h14;
    set_empty(5'b11111);

    // 1: reset and release with all FIFOs empty
    #1;
    check_eq("rst_idle", 32'(bus.IDLE), 0);
    check_eq("rst_valid", 32'(bus.valid), 0);
    check_eq("rst_data", 32'(bus.data_out), 0);
    check_eq("rst_idx", 32'(bus.idx), 0);
    check_eq("rst_pops", pops(), 0);
    #1 reset_L = 1'b1;
    tick();
    check_eq("init_idle", 32'(bus.IDLE), 0);
    tick();
    check_eq("s1_idle", 32'(bus.IDLE), 1);
    check_eq("s1_pops", pops(), 0);
    check_eq("s1_valid", 32'(bus.valid), 0);
    check_eq("s1_data", 32'(bus.data_out), 0);

    // 2: all five non-empty, strict 0..4,0 order
    set_empty(5'b00000);
    for (int i = 0; i < 6; i++) begin
      #1 check_eq("s2_pop", pops(), 32'(1) << (i % 5));
      if (i == 0) check_eq("s2_idle_hold", 32'(bus.IDLE), 1);
      tick();
      check_word("s2", 32'(i % 5));
      check_eq("s2_idle", 32'(bus.IDLE), 0);
    end

    // 3: only fifo3 non-empty for four cycles (pointer at 1)
    set_empty(5'b10111);
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("s3_pop", pops(), 32'h08);
      tick();
      check_word("s3", 3);
    end
    set_empty(5'b11111);
    #1 check_eq("s3_nopop", pops(), 0);
    tick();
    check_eq("s3_idle", 32'(bus.IDLE), 1);
    check_eq("s3_valid", 32'(bus.valid), 0);
    check_eq("s3_data_hold", 32'(bus.data_out), 32'h13);
    check_eq("s3_idx_hold", 32'(bus.idx), 3);

    // 4: move pointer to 3 via fifo2, then FIFOs 1 and 4 -> 4,1,4
    set_empty(5'b11011);
    #1 check_eq("s4_pop2", pops(), 32'h04);
    tick();
    check_word("s4_w2", 2);
    set_empty(5'b01101);
    #1 check_eq("s4_pop4a", pops(), 32'h10);
    tick();
    check_word("s4_w4a", 4);
    #1 check_eq("s4_pop1", pops(), 32'h02);
    tick();
    check_word("s4_w1", 1);
    #1 check_eq("s4_pop4b", pops(), 32'h10);
    tick();
    check_word("s4_w4b", 4);

    // 5: pause three cycles with pointer held at 1
    set_empty(5'b00000);
    #1 check_eq("s5_pop0", pops(), 32'h01);
    tick();
    check_word("s5_w0", 0);
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("s5_paused_pop", pops(), 0);
      tick();
      check_eq("s5_paused_valid", 32'(bus.valid), 0);
      check_eq("s5_paused_idx", 32'(bus.idx), 0);
      check_eq("s5_paused_idle", 32'(bus.IDLE), 1);
    end
    bus.pause = 1'b0;
    #1 check_eq("s5_resume_pop", pops(), 32'h02);
    tick();
    check_word("s5_w1", 1);
    #1 check_eq("s6_pre_pop2", pops(), 32'h04);

    // 6: asynchronous reset while valid=1 and fifo2_pop=1
    #1 reset_L = 1'b0;
    #1;
    check_eq("s6_pops", pops(), 0);
    check_eq("s6_valid", 32'(bus.valid), 0);
    check_eq("s6_data", 32'(bus.data_out), 0);
    check_eq("s6_idle", 32'(bus.IDLE), 0);
    check_eq("s6_idx", 32'(bus.idx), 0);
    reset_L = 1'b1;
    #1 check_eq("s6_rst_pops", pops(), 0);
    tick();
    check_eq("s6_init_pops", pops(), 0);
    check_eq("s6_init_valid", 32'(bus.valid), 0);
    tick();
    check_eq("s6_idle_back", 32'(bus.IDLE), 1);
    check_eq("s6_ptr0_pop", pops(), 32'h01);
    tick();
    check_word("s6_w0", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
